apu_triangle: RTL and testbench
===============================

APU_TRIANGLE -- requirements
Module: apu_triangle

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by the NES APU triangle channel definition.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_l  input  1  asynchronous, active-low reset.
REQ-004 cpu_cyc_en  input  1  one-cycle pulse per emulated CPU cycle; gates the timer.
REQ-005 quarter_frame  input  1  one-cycle pulse from the frame counter; clocks the linear counter.
REQ-006 half_frame  input  1  one-cycle pulse from the frame counter; clocks the length counter.
REQ-007 reg_we  input  1  register write strobe, one cycle per write.
REQ-008 reg_addr  input  2  register select: 0=$4008, 1=$4009 (unused), 2=$400A, 3=$400B.
REQ-009 reg_wdata  input  8  register write data.
REQ-010 chan_en  input  1  $4015 bit 2 (channel enable).
REQ-011 tri_out  output  4  current sequencer sample, 0..15, to the mixer/DAC path.
REQ-012 len_active  output  1  high when the length counter is nonzero, for the $4015 status read.

Function
REQ-013 A $4008 write SHALL latch control_flag=wdata[7] and lin_reload_val=wdata[6:0].
REQ-014 A $400A write SHALL latch period[7:0]=wdata.
REQ-015 A $400B write SHALL latch period[10:8]=wdata[2:0] and set lin_reload_flag.
REQ-016 A $400B write with chan_en=1 SHALL load the length counter with LEN_TABLE[wdata[7:3]].
REQ-017 A $400B write with chan_en=0 SHALL leave the length counter at 0.
REQ-018 A $4009 write SHALL have no effect.
REQ-019 The timer SHALL be an 11-bit down-counter that changes only on cycles where cpu_cyc_en=1.
REQ-020 On a cpu_cyc_en cycle with timer!=0, the timer SHALL decrement by 1.
REQ-021 On a cpu_cyc_en cycle with timer==0, the timer SHALL reload from period.
REQ-022 On that same reload cycle, the sequencer SHALL advance only if the linear counter!=0 and the length counter!=0.
REQ-023 The sequencer step SHALL be 5 bits and wrap from 31 to 0.
REQ-024 tri_out SHALL equal SEQ_TABLE[step], where SEQ_TABLE = 15,14,...,1,0,0,1,...,15.
REQ-025 tri_out SHALL be registered or decoded from the step register and SHALL hold its value while the sequencer is halted.
REQ-026 On quarter_frame with lin_reload_flag=1, the linear counter SHALL load lin_reload_val.
REQ-027 On quarter_frame with lin_reload_flag=0 and linear counter!=0, the linear counter SHALL decrement; a counter at 0 SHALL stay 0.
REQ-028 On quarter_frame with control_flag=0, lin_reload_flag SHALL be cleared after the linear counter update.
REQ-029 On half_frame with length!=0 and control_flag=0 (halt clear), the length counter SHALL decrement.
REQ-030 chan_en=0 SHALL force the length counter to 0 on the next clk edge, overriding loads and decrements.
REQ-031 Simultaneous $400B write and half_frame: the table load SHALL win and no decrement SHALL occur that cycle.
REQ-032 Simultaneous $400B write and quarter_frame: the write-set lin_reload_flag SHALL take effect from the next quarter_frame.
REQ-033 period values 0 and 1 SHALL be legal: the sequencer then advances every 1 or 2 enabled cycles; there SHALL be no ultrasonic muting.
REQ-034 len_active SHALL be (length counter != 0), combinational from state.

Reset
REQ-035 While rst_l=0, the following SHALL be 0: period, timer, step, linear counter, length counter, lin_reload_val, control_flag and lin_reload_flag.
REQ-036 While rst_l=0, tri_out SHALL be 4'hF (SEQ_TABLE[0]) and len_active SHALL be 0.
REQ-037 Reset assertion mid-operation SHALL clear state immediately, without waiting for clk.
REQ-038 After reset release, the first enabled cycle SHALL see timer==0 and reload from period.

Structure
REQ-039 LEN_TABLE (32x8: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30), SEQ_TABLE and the register-address enum SHALL reside in the shared package apu_pkg.
REQ-040 The length counter SHALL be a sub-module, apu_length_counter (load, halt, enable, half_frame), so the pulse and noise channels can reuse it.

Verification
REQ-041 Write $4008=0x81, $400A=0x02, $400B=0x08 (chan_en=1), one quarter_frame, then 3 cpu_cyc_en pulses -> step advances once, tri_out 15->14.
REQ-042 Run 96 cpu_cyc_en pulses with period=2 and both counters nonzero -> 32 steps, tri_out sequence 15..0,0..15, then back to 15.
REQ-043 $4008=0x03 (control clear), $400B write, 4 quarter_frames -> linear counter 3,2,1,0; sequencer frozen and tri_out held after it reaches 0.
REQ-044 $400B=0x08 (LEN_TABLE[1]=254), $4008 bit7=0, 254 half_frames -> len_active falls on the 254th; with bit7=1, len_active stays 1.
REQ-045 $400B write and half_frame in the same cycle -> length equals the table value, not value-1; chan_en=0 -> len_active=0 on the next edge.
REQ-046 Assert rst_l low mid-sequence, asynchronously to clk -> tri_out=4'hF and len_active=0 before the next clk edge.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared NES APU definitions: register map, length-counter load table and the
// triangle sequencer waveform.
package apu_pkg;

  typedef enum logic [1:0] {
    REG_LINEAR   = 2'd0,  // $4008
    REG_UNUSED   = 2'd1,  // $4009
    REG_TIMER_LO = 2'd2,  // $400A
    REG_TIMER_HI = 2'd3   // $400B
  } tri_reg_e;

  localparam int TIMER_W = 11;
  localparam int LIN_W   = 7;
  localparam int LEN_W   = 8;
  localparam int STEP_W  = 5;

  // LEN_TABLE: length-counter load values indexed by $400B[7:3].
  function automatic logic [LEN_W-1:0] len_lookup(input logic [4:0] idx);
    logic [LEN_W-1:0] val;
    unique case (idx)
      5'd0:  val = 8'd10;
      5'd1:  val = 8'd254;
      5'd2:  val = 8'd20;
      5'd3:  val = 8'd2;
      5'd4:  val = 8'd40;
      5'd5:  val = 8'd4;
      5'd6:  val = 8'd80;
      5'd7:  val = 8'd6;
      5'd8:  val = 8'd160;
      5'd9:  val = 8'd8;
      5'd10: val = 8'd60;
      5'd11: val = 8'd10;
      5'd12: val = 8'd14;
      5'd13: val = 8'd12;
      5'd14: val = 8'd26;
      5'd15: val = 8'd14;
      5'd16: val = 8'd12;
      5'd17: val = 8'd16;
      5'd18: val = 8'd24;
      5'd19: val = 8'd18;
      5'd20: val = 8'd48;
      5'd21: val = 8'd20;
      5'd22: val = 8'd96;
      5'd23: val = 8'd22;
      5'd24: val = 8'd192;
      5'd25: val = 8'd24;
      5'd26: val = 8'd72;
      5'd27: val = 8'd26;
      5'd28: val = 8'd16;
      5'd29: val = 8'd28;
      5'd30: val = 8'd32;
      default: val = 8'd30;
    endcase
    return val;
  endfunction

  // SEQ_TABLE: 15,14..1,0,0,1..14,15. The falling half is the bitwise
  // complement of the step, the rising half is the step's low nibble.
  function automatic logic [3:0] seq_lookup(input logic [STEP_W-1:0] step);
    return step[4] ? step[3:0] : ~step[3:0];
  endfunction

endpackage

// File: rtl/apu_length_counter.sv
// Length counter shared by the pulse, triangle and noise channels: table load,
// half-frame decrement unless halted, forced to zero while the channel is off.
module apu_length_counter
  import apu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_l,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             halt,
  input  logic             enable,
  input  logic             half_frame,
  output logic             active
);

  logic [LEN_W-1:0] count;

  // Disable beats a load, and a load beats a coincident half-frame clock.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (half_frame && !halt && (count != '0)) begin
      count <= count - 8'd1;
    end
  end

  assign active = (count != '0);

endmodule

// File: rtl/apu_triangle.sv
// NES APU triangle channel: register file, 11-bit timer, linear counter,
// shared length counter and the 32-step triangle sequencer.
module apu_triangle
  import apu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_l,
  input  logic       cpu_cyc_en,
  input  logic       quarter_frame,
  input  logic       half_frame,
  input  logic       reg_we,
  input  logic [1:0] reg_addr,
  input  logic [7:0] reg_wdata,
  input  logic       chan_en,
  output logic [3:0] tri_out,
  output logic       len_active
);

  tri_reg_e reg_sel;
  logic     wr_linear;
  logic     wr_timer_lo;
  logic     wr_timer_hi;

  logic               control_flag;
  logic [LIN_W-1:0]   lin_reload_val;
  logic               lin_reload_flag;
  logic [LIN_W-1:0]   lin_cnt;
  logic [TIMER_W-1:0] period;
  logic [TIMER_W-1:0] timer;
  logic [STEP_W-1:0]  step;
  logic               timer_expire;
  logic               seq_advance;

  assign reg_sel     = tri_reg_e'(reg_addr);
  assign wr_linear   = reg_we && (reg_sel == REG_LINEAR);
  assign wr_timer_lo = reg_we && (reg_sel == REG_TIMER_LO);
  assign wr_timer_hi = reg_we && (reg_sel == REG_TIMER_HI);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      control_flag   <= 1'b0;
      lin_reload_val <= '0;
    end else if (wr_linear) begin
      control_flag   <= reg_wdata[7];
      lin_reload_val <= reg_wdata[6:0];
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      period <= '0;
    end else begin
      if (wr_timer_lo) period[7:0]  <= reg_wdata;
      if (wr_timer_hi) period[10:8] <= reg_wdata[2:0];
    end
  end

  // A $400B write landing on a quarter-frame sets the flag after this
  // quarter-frame has already used the old value.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      lin_reload_flag <= 1'b0;
    end else if (wr_timer_hi) begin
      lin_reload_flag <= 1'b1;
    end else if (quarter_frame && !control_flag) begin
      lin_reload_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      lin_cnt <= '0;
    end else if (quarter_frame) begin
      if (lin_reload_flag) begin
        lin_cnt <= lin_reload_val;
      end else if (lin_cnt != '0) begin
        lin_cnt <= lin_cnt - 7'd1;
      end
    end
  end

  apu_length_counter u_len (
    .clk        (clk),
    .rst_l      (rst_l),
    .load       (wr_timer_hi),
    .load_val   (len_lookup(reg_wdata[7:3])),
    .halt       (control_flag),
    .enable     (chan_en),
    .half_frame (half_frame),
    .active     (len_active)
  );

  // ---- timer stage: reload on zero, sequencer clocked on the reload ----
  assign timer_expire = cpu_cyc_en && (timer == '0);
  assign seq_advance  = timer_expire && (lin_cnt != '0) && len_active;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      timer <= '0;
    end else if (cpu_cyc_en) begin
      if (timer == '0) begin
        timer <= period;
      end else begin
        timer <= timer - 11'd1;
      end
    end
  end

  // ---- sequencer stage: no ultrasonic mute, low periods play as-is ----
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      step <= '0;
    end else if (seq_advance) begin
      step <= step + 5'd1;
    end
  end

  assign tri_out = seq_lookup(step);

endmodule

// File: tb/tb_apu_triangle.sv
// Directed bench for apu_triangle: register writes, timer/sequencer stepping,
// linear and length counters, and asynchronous reset.
module tb_apu_triangle;

  logic       clk;
  logic       rst_l;
  logic       cpu_cyc_en;
  logic       quarter_frame;
  logic       half_frame;
  logic       reg_we;
  logic [1:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       chan_en;
  logic [3:0] tri_out;
  logic       len_active;

  int errors = 0;
  int checks = 0;

  int seq_exp [32] = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0,
                       0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};

  apu_triangle dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .cpu_cyc_en    (cpu_cyc_en),
    .quarter_frame (quarter_frame),
    .half_frame    (half_frame),
    .reg_we        (reg_we),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .chan_en       (chan_en),
    .tri_out       (tri_out),
    .len_active    (len_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic qf();
    quarter_frame = 1'b1; tick(); quarter_frame = 1'b0;
  endtask

  task automatic hf();
    half_frame = 1'b1; tick(); half_frame = 1'b0;
  endtask

  // One enabled CPU cycle followed by one idle cycle.
  task automatic pulse();
    cpu_cyc_en = 1'b1; tick(); cpu_cyc_en = 1'b0; tick();
  endtask

  initial begin
    int exp_step;
    rst_l = 1'b0; cpu_cyc_en = 1'b0; quarter_frame = 1'b0; half_frame = 1'b0;
    reg_we = 1'b0; reg_addr = 2'd0; reg_wdata = 8'd0; chan_en = 1'b0;
    #3;
    chk("rst_tri_out", tri_out, 15);
    chk("rst_len_active", len_active, 0);
    tick(); tick();
    rst_l = 1'b1;
    tick();
    chk("post_rst_tri_out", tri_out, 15);

    // First step after a linear-counter load
    chan_en = 1'b1;
    wr(2'd0, 8'h81);
    wr(2'd2, 8'h02);
    wr(2'd3, 8'h08);
    chk("len_loaded", len_active, 1);
    qf();
    chk("no_step_before_cyc", tri_out, 15);
    pulse();
    chk("first_pulse_step", tri_out, 14);
    pulse(); pulse();
    chk("three_pulses_one_step", tri_out, 14);

    // Full waveform with period 2: one step per three enabled cycles
    exp_step = 1;
    for (int p = 0; p < 96; p++) begin
      pulse();
      if (p % 3 == 0) exp_step = (exp_step + 1) % 32;
      chk($sformatf("wave_p%0d", p), tri_out, seq_exp[exp_step]);
    end
    chk("wave_wrapped", tri_out, 14);

    // Period 0 advances every enabled cycle, period 1 every second one
    wr(2'd2, 8'h00);
    pulse(); chk("per0_a", tri_out, 13);
    pulse(); chk("per0_b", tri_out, 12);
    pulse(); chk("per0_c", tri_out, 11);
    pulse(); chk("per0_d", tri_out, 10);
    wr(2'd2, 8'h01);
    pulse(); chk("per1_a", tri_out, 9);
    pulse(); chk("per1_b", tri_out, 9);
    pulse(); chk("per1_c", tri_out, 8);
    pulse(); chk("per1_d", tri_out, 8);

    // Linear counter 3,2,1,0 then the sequencer freezes
    wr(2'd2, 8'h00);
    wr(2'd0, 8'h03);
    wr(2'd3, 8'h08);
    qf(); pulse(); chk("lin3_step", tri_out, 7);
    qf(); pulse(); chk("lin2_step", tri_out, 6);
    qf(); pulse(); chk("lin1_step", tri_out, 5);
    qf(); pulse(); pulse(); pulse();
    chk("lin0_held", tri_out, 5);
    qf(); pulse();
    chk("lin0_stays", tri_out, 5);

    // Length counter 254 counts down with halt clear
    for (int i = 0; i < 253; i++) hf();
    chk("len_253_hf", len_active, 1);
    hf();
    chk("len_254_hf", len_active, 0);
    hf();
    chk("len_stays_0", len_active, 0);
    wr(2'd0, 8'h83);
    wr(2'd3, 8'h08);
    for (int i = 0; i < 300; i++) hf();
    chk("len_halted", len_active, 1);

    // Table load wins over a coincident half-frame (index 3 -> 2)
    wr(2'd0, 8'h03);
    reg_we = 1'b1; reg_addr = 2'd3; reg_wdata = 8'h18; half_frame = 1'b1;
    tick();
    reg_we = 1'b0; half_frame = 1'b0;
    hf(); chk("len_sim_hf1", len_active, 1);
    hf(); chk("len_sim_hf2", len_active, 0);

    // Reload flag set by a write on a quarter-frame waits for the next one
    wr(2'd0, 8'h00);
    wr(2'd3, 8'h08);
    qf();
    wr(2'd0, 8'h05);
    reg_we = 1'b1; reg_addr = 2'd3; reg_wdata = 8'h08; quarter_frame = 1'b1;
    tick();
    reg_we = 1'b0; quarter_frame = 1'b0;
    pulse(); chk("qf_sim_no_reload", tri_out, 5);
    qf(); pulse(); chk("qf_next_reload", tri_out, 4);

    // $4009 is ignored
    wr(2'd1, 8'hFF);
    chk("w4009_tri", tri_out, 4);
    chk("w4009_len", len_active, 1);

    // Channel disable clears the length counter on the next edge
    chan_en = 1'b0;
    #1;
    chk("dis_before_edge", len_active, 1);
    tick();
    chk("dis_after_edge", len_active, 0);
    wr(2'd3, 8'h08);
    chk("dis_write_ignored", len_active, 0);

    // Asynchronous reset mid-operation
    chan_en = 1'b1;
    wr(2'd3, 8'h08);
    chk("pre_rst_len", len_active, 1);
    @(posedge clk);
    #2;
    rst_l = 1'b0;
    #1;
    chk("async_rst_tri", tri_out, 15);
    chk("async_rst_len", len_active, 0);
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    tick();

    // After reset the first enabled cycle reloads from period
    wr(2'd0, 8'h81);
    wr(2'd2, 8'h05);
    wr(2'd3, 8'h08);
    qf();
    pulse(); chk("rst_first_reload", tri_out, 14);
    for (int i = 0; i < 5; i++) pulse();
    chk("rst_p5_hold", tri_out, 14);
    pulse(); chk("rst_p5_next", tri_out, 13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
